kernel_a_stream_feeder: RTL and testbench

//   Upstream feeder for the kernel_A top. Takes one packed memory-side word stream
//   and splits each word into the two lane inputs vin0/vin1 the kernel consumes.

---
 rtl/kernel_a_feeder_pkg.sv | 15 +
 rtl/stream_fifo_fwft.sv | 70 +++++++
 rtl/kernel_a_stream_feeder.sv | 112 +++++++++++
 tb/tb_kernel_a_stream_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kernel_a_feeder_pkg.sv
// Shared types and default sizes for the kernel_A stream feeder.
package kernel_a_feeder_pkg;

  localparam int STREAMW_DEF  = 32;
  localparam int FIFO_AW_DEF  = 4;
  localparam int NELEMS_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/stream_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head word is visible whenever not empty.
module stream_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Outputs read as zero while empty so nothing stale leaks out after a flush.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/kernel_a_stream_feeder.sv
// Splits packed memory words into the kernel's two lanes through a FWFT buffer and
// sequences one counted run per start pulse.
//   state    | meaning
//   ST_IDLE  | waiting for start, nothing accepted
//   ST_RUN   | accepting words until nelems have been pushed
//   ST_DRAIN | all words in, waiting for the last pop
//   ST_DONE  | one-cycle done pulse, then back to idle
module kernel_a_stream_feeder
  import kernel_a_feeder_pkg::*;
#(
  parameter int STREAMW  = STREAMW_DEF,
  parameter int FIFO_AW  = FIFO_AW_DEF,
  parameter int NELEMS_W = NELEMS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NELEMS_W-1:0]  nelems,
  output logic                 busy,
  output logic                 done,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [2*STREAMW-1:0] mem_data,
  output logic                 ovalid,
  input  logic                 oready,
  output logic [STREAMW-1:0]   vin0_s0,
  output logic [STREAMW-1:0]   vin1_s0,
  output logic [FIFO_AW:0]     fill_level
);

  feeder_state_e        state_q, state_d;
  logic [NELEMS_W-1:0]  nelems_q, nelems_d;
  logic [NELEMS_W-1:0]  in_cnt_q, in_cnt_d;
  logic [NELEMS_W-1:0]  out_cnt_q, out_cnt_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*STREAMW-1:0] fifo_rdata;
  logic                 push;
  logic                 pop;

  // Ready looks only at state and occupancy; a pop in the same cycle never frees a full slot.
  assign mem_ready = (state_q == ST_RUN) & ~fifo_full;
  assign push      = mem_valid & mem_ready;
  assign ovalid    = ~fifo_empty;
  assign pop       = ovalid & oready;
  assign busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign vin0_s0   = fifo_rdata[STREAMW-1:0];
  assign vin1_s0   = fifo_rdata[2*STREAMW-1:STREAMW];

  stream_fifo_fwft #(
    .WIDTH (2*STREAMW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (mem_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  always_comb begin
    state_d   = state_q;
    nelems_d  = nelems_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nelems_d  = nelems;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (nelems != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // The final pop always trails the final push, so RUN never jumps straight to DONE.
        if (push) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_d == nelems_q) state_d = ST_DRAIN;
        end
        if (pop) out_cnt_d = out_cnt_q + 1'b1;
      end
      ST_DRAIN: begin
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_d == nelems_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nelems_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nelems_q  <= nelems_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_kernel_a_stream_feeder.sv
// Directed bench for kernel_a_stream_feeder with a queue-based reference model.
module tb_kernel_a_stream_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] nelems = '0;
  logic        busy, done;
  logic        mem_valid = 1'b1;
  logic        mem_ready;
  logic [63:0] mem_data = '0;
  logic        ovalid;
  logic        oready = 1'b0;
  logic [31:0] vin0_s0, vin1_s0;
  logic [4:0]  fill_level;

  int errors = 0;
  int checks = 0;

  kernel_a_stream_feeder dut (
    .clk(clk), .rst(rst), .start(start), .nelems(nelems), .busy(busy), .done(done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .ovalid(ovalid), .oready(oready), .vin0_s0(vin0_s0), .vin1_s0(vin1_s0),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_word(input int k);
    return {32'(2*k + 2), 32'(2*k + 1)};
  endfunction

  // Reference model: a queue of words in flight plus run bookkeeping.
  logic [63:0] m_q[$];
  logic [63:0] pop_log[$];
  bit          m_busy = 0;
  bit          m_done = 0;
  int unsigned m_n = 0, m_pushed = 0, m_popped = 0;
  int          m_idx = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    int sz;
    bit exp_mr, exp_ov, push_m, pop_m, done_n;
    sz     = m_q.size();
    exp_mr = m_busy && (m_pushed < m_n) && (sz < 16);
    exp_ov = (sz > 0);
    chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
    chk("ovalid", 64'(ovalid), 64'(exp_ov));
    chk("fill_level", 64'(fill_level), 64'(sz));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    if (exp_ov) begin
      chk("vin0_s0", 64'(vin0_s0), 64'(m_q[0][31:0]));
      chk("vin1_s0", 64'(vin1_s0), 64'(m_q[0][63:32]));
    end
    if (ovalid && oready) pop_log.push_back({vin1_s0, vin0_s0});
    if (done) done_cnt++;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_done = 0; m_n = 0; m_pushed = 0; m_popped = 0;
    end else begin
      pop_m  = exp_ov && oready;
      push_m = mem_valid && exp_mr;
      done_n = 0;
      if (pop_m) begin
        void'(m_q.pop_front());
        m_popped++;
      end
      if (push_m) begin
        m_q.push_back(mem_data);
        m_pushed++;
        m_idx++;
      end
      if (m_busy && m_popped == m_n) begin
        m_busy = 0;
        done_n = 1;
      end else if (!m_busy && !m_done && start) begin
        if (nelems == 0) done_n = 1;
        else begin
          m_busy = 1; m_n = nelems; m_pushed = 0; m_popped = 0;
        end
      end
      m_done = done_n;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    mem_data = mk_word(m_idx);
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1; nelems = 32'(n);
    cyc();
    start = 1'b0; nelems = 32'hdead_beef;
  endtask

  task automatic wait_done(input int max, input string name);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cyc();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    int d0;
    bit hit;
    // 1: reset with mem_valid held high
    repeat (3) cyc();
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_vin0", 64'(vin0_s0), 64'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // 2: basic run of 4 words
    pop_log.delete();
    oready = 1'b1;
    d0 = done_cnt;
    pulse_start(4);
    wait_done(40, "basic_done");
    repeat (3) cyc();
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
    chk("basic_npop", 64'(pop_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
      chk("basic_vin0", 64'(pop_log[i][31:0]), 64'(2*i + 1));
      chk("basic_vin1", 64'(pop_log[i][63:32]), 64'(2*i + 2));
    end

    // 3/4: fill to 16, then simultaneous push and pop at full
    pop_log.delete();
    oready = 1'b0;
    d0 = done_cnt;
    pulse_start(20);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (fill_level == 5'd16) begin hit = 1; break; end
    end
    chk("full_reached", 64'(hit), 64'd1);
    cyc();
    chk("full_fill", 64'(fill_level), 64'd16);
    chk("full_mem_ready", 64'(mem_ready), 64'd0);
    oready = 1'b1;
    cyc();
    chk("full_pop_only", 64'(fill_level), 64'd15);
    chk("full_ready_back", 64'(mem_ready), 64'd1);
    cyc();
    chk("full_push_pop", 64'(fill_level), 64'd15);
    wait_done(100, "full_done");
    repeat (3) cyc();
    chk("full_done_once", 64'(done_cnt - d0), 64'd1);
    chk("full_npop", 64'(pop_log.size()), 64'd20);
    if (pop_log.size() == 20) begin
      chk("full_first", pop_log[0], 64'h0000000a_00000009);
      chk("full_last", pop_log[19], 64'h00000030_0000002f);
    end

    // 5: zero-length run
    d0 = done_cnt;
    pulse_start(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_no_ready", 64'(mem_ready), 64'd0);
    cyc();
    chk("zero_done_off", 64'(done), 64'd0);
    chk("zero_ovalid", 64'(ovalid), 64'd0);
    repeat (2) cyc();
    chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

    // 6: reset in the middle of a run
    oready = 1'b0;
    d0 = done_cnt;
    pulse_start(10);
    repeat (5) cyc();
    chk("mid_fill5", 64'(fill_level), 64'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_fill0", 64'(fill_level), 64'd0);
    chk("mid_busy0", 64'(busy), 64'd0);
    repeat (4) cyc();
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    pop_log.delete();
    oready = 1'b1;
    pulse_start(2);
    wait_done(40, "restart_done");
    repeat (3) cyc();
    chk("restart_done_once", 64'(done_cnt - d0), 64'd1);
    chk("restart_npop", 64'(pop_log.size()), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
